// File: rtl/morph_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : morph_program_sequencer
// Brief    : Issues a loadable opcode program to the morphologic processor for
//            N passes, then captures and streams the accumulated image as words.
// Revision : 1.0 - initial release
// ============================================================================
module morph_program_sequencer #(
    parameter int ImageWidth    = 8,
    parameter int ImageHeight   = 4,
    parameter int OpcodeWidth   = 16,
    parameter int ProgAddrWidth = 3,
    parameter int WordWidth     = 8,
    parameter int PassWidth     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           prog_we,
    input  logic [ProgAddrWidth-1:0]       prog_addr,
    input  logic [OpcodeWidth-1:0]         prog_data,
    input  logic [ProgAddrWidth:0]         prog_len,
    input  logic [PassWidth-1:0]           passes,
    input  logic                           start,
    input  logic                           abort,
    output logic                           op_valid,
    output logic [OpcodeWidth-1:0]         op_code,
    output logic                           op_first,
    input  logic                           op_ack,
    input  logic [ImageWidth*ImageHeight-1:0] image_acc,
    output logic                           out_valid,
    output logic [WordWidth-1:0]           out_data,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done
);

    localparam int c_ImgBits  = ImageWidth * ImageHeight;
    localparam int c_NumWords = c_ImgBits / WordWidth;
    localparam int c_WcWidth  = (c_NumWords > 1) ? $clog2(c_NumWords) : 1;
    localparam int c_Depth    = 1 << ProgAddrWidth;

    localparam logic [2:0] c_StIdle    = 3'd0;
    localparam logic [2:0] c_StIssue   = 3'd1;
    localparam logic [2:0] c_StCapture = 3'd2;
    localparam logic [2:0] c_StDump    = 3'd3;
    localparam logic [2:0] c_StDone    = 3'd4;

    logic [2:0]               r_state;
    logic [OpcodeWidth-1:0]   r_prog [c_Depth];
    logic [ProgAddrWidth:0]   r_len;
    logic [PassWidth-1:0]     r_passes;
    logic [ProgAddrWidth-1:0] r_pc;
    logic [PassWidth-1:0]     r_pass;
    logic [c_WcWidth-1:0]     r_wordCnt;
    logic [c_ImgBits-1:0]     r_shift;
    logic                     r_opValid;
    logic [OpcodeWidth-1:0]   r_opCode;
    logic                     r_opFirst;
    logic                     r_outValid;
    logic                     r_busy;
    logic                     r_done;

    logic                     w_progWrite;
    logic [OpcodeWidth-1:0]   w_firstOp;
    logic [ProgAddrWidth-1:0] w_nextPc;
    logic                     w_pcLast;
    logic                     w_passLast;
    logic                     w_lastWord;

    assign w_progWrite = prog_we && (r_state == c_StIdle);
    // A write to slot 0 coinciding with start must be visible to the first issue.
    assign w_firstOp   = (w_progWrite && (prog_addr == '0)) ? prog_data : r_prog[0];
    assign w_nextPc    = r_pc + ProgAddrWidth'(1);
    assign w_pcLast    = ({1'b0, r_pc} + (ProgAddrWidth+1)'(1)) >= r_len;
    assign w_passLast  = ({1'b0, r_pass} + (PassWidth+1)'(1)) >= {1'b0, r_passes};
    assign w_lastWord  = (r_wordCnt == c_WcWidth'(c_NumWords - 1));

    always_ff @(posedge clk) begin
        if (w_progWrite) begin
            r_prog[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_StIdle;
            r_len      <= '0;
            r_passes   <= '0;
            r_pc       <= '0;
            r_pass     <= '0;
            r_wordCnt  <= '0;
            r_shift    <= '0;
            r_opValid  <= 1'b0;
            r_opCode   <= '0;
            r_opFirst  <= 1'b0;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != c_StIdle)) begin
                r_state    <= c_StIdle;
                r_opValid  <= 1'b0;
                r_opFirst  <= 1'b0;
                r_outValid <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    c_StIdle: begin
                        if (start) begin
                            r_len    <= prog_len;
                            r_passes <= (passes == '0) ? PassWidth'(1) : passes;
                            r_pc     <= '0;
                            r_pass   <= '0;
                            r_busy   <= 1'b1;
                            if (prog_len == '0) begin
                                r_state <= c_StCapture;
                            end else begin
                                r_state   <= c_StIssue;
                                r_opValid <= 1'b1;
                                r_opFirst <= 1'b1;
                                r_opCode  <= w_firstOp;
                            end
                        end
                    end
                    c_StIssue: begin
                        if (op_ack) begin
                            r_opFirst <= 1'b0;
                            if (!w_pcLast) begin
                                r_pc     <= w_nextPc;
                                r_opCode <= r_prog[w_nextPc];
                            end else if (!w_passLast) begin
                                r_pc     <= '0;
                                r_pass   <= r_pass + PassWidth'(1);
                                r_opCode <= r_prog[0];
                            end else begin
                                r_opValid <= 1'b0;
                                r_state   <= c_StCapture;
                            end
                        end
                    end
                    c_StCapture: begin
                        r_shift    <= image_acc;
                        r_wordCnt  <= '0;
                        r_outValid <= 1'b1;
                        r_state    <= c_StDump;
                    end
                    c_StDump: begin
                        if (out_ready) begin
                            r_shift   <= r_shift << WordWidth;
                            r_wordCnt <= r_wordCnt + c_WcWidth'(1);
                            if (w_lastWord) begin
                                r_outValid <= 1'b0;
                                r_done     <= 1'b1;
                                r_state    <= c_StDone;
                            end
                        end
                    end
                    c_StDone: begin
                        r_busy  <= 1'b0;
                        r_state <= c_StIdle;
                    end
                    default: begin
                        r_state <= c_StIdle;
                    end
                endcase
            end
        end
    end

    assign op_valid  = r_opValid;
    assign op_code   = r_opCode;
    assign op_first  = r_opFirst;
    assign out_valid = r_outValid;
    assign out_data  = r_shift[c_ImgBits-1 -: WordWidth];
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_morph_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_morph_program_sequencer
// Brief    : Randomised self-checking bench with a run-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morph_program_sequencer;

    localparam int IW = 8, IH = 4, OW = 16, AW = 3, WW = 8, PW = 4;
    localparam int IB = IW * IH;
    localparam int NW = IB / WW;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [OW-1:0] prog_data = '0;
    logic [AW:0]   prog_len = '0;
    logic [PW-1:0] passes = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          op_valid;
    logic [OW-1:0] op_code;
    logic          op_first;
    logic          op_ack = 1'b0;
    logic [IB-1:0] image_acc = '0;
    logic          out_valid;
    logic [WW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          done;

    morph_program_sequencer dut (
        .clk(clk), .rst(rst),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_len(prog_len), .passes(passes), .start(start), .abort(abort),
        .op_valid(op_valid), .op_code(op_code), .op_first(op_first), .op_ack(op_ack),
        .image_acc(image_acc),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int nTotal = 0;
    int nBad   = 0;
    logic [OW-1:0] model [DEPTH];

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTotal++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic writeProg(input int addr, input logic [OW-1:0] data);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = AW'(addr); prog_data = data;
        @(negedge clk);
        prog_we = 1'b0;
        model[addr] = data;
    endtask

    // ackMode: 0 immediate, 1 two-cycle wait, 2 random 0..2.
    // readyMode: 0 always, 1 pattern 1,0,0 repeating, 2 random.
    task automatic runSeq(input string tag, input int len, input int nPass,
                          input int ackMode, input int readyMode, input int abortWord,
                          input bit junk, input bit wrOnStart, input logic [OW-1:0] wrData,
                          input logic [IB-1:0] img);
        int p, cyc, waitLeft, waits, stalls, busyCnt, doneCnt, opSeen, kReady;
        int firstOpCyc, firstOutCyc, lastAckCyc;
        bit offer, stalled, aborted, finished;
        logic [OW-1:0] heldOp, expOp[$], gotOp[$];
        bit heldFirst, expFirst[$], gotFirst[$];
        logic [WW-1:0] heldData, expW[$], gotW[$];

        if (wrOnStart) model[0] = wrData;
        p = (nPass == 0) ? 1 : nPass;
        for (int r = 0; r < p; r++)
            for (int i = 0; i < len; i++) begin
                expOp.push_back(model[i]);
                expFirst.push_back(r == 0 && i == 0);
            end
        for (int w = 0; w < NW; w++) expW.push_back(img[IB-1-w*WW -: WW]);

        @(negedge clk);
        image_acc = img; prog_len = (AW+1)'(len); passes = PW'(nPass); start = 1'b1;
        if (wrOnStart) begin
            prog_we = 1'b1; prog_addr = '0; prog_data = wrData;
        end
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;

        cyc = 1; waits = 0; stalls = 0; busyCnt = 0; doneCnt = 0; opSeen = 0; kReady = 0;
        firstOpCyc = -1; firstOutCyc = -1; lastAckCyc = -1; waitLeft = 0;
        offer = 0; stalled = 0; aborted = 0; finished = 0; heldOp = '0; heldFirst = 0; heldData = '0;

        while (cyc < 600) begin
            if (doneCnt > 0 && !busy) begin
                finished = 1;
                break;
            end
            if (busy) busyCnt++;
            if (done) doneCnt++;

            if (op_valid) begin
                opSeen++;
                if (firstOpCyc < 0) firstOpCyc = cyc;
                if (!offer) begin
                    offer = 1; heldOp = op_code; heldFirst = op_first;
                    waitLeft = (ackMode == 0) ? 0 : (ackMode == 1) ? 2 : int'($urandom_range(0, 2));
                end else begin
                    checkVal({tag, " op_code_held"}, 64'(op_code), 64'(heldOp));
                    checkVal({tag, " op_first_held"}, 64'(op_first), 64'(heldFirst));
                end
                if (waitLeft == 0) begin
                    op_ack = 1'b1; offer = 0; lastAckCyc = cyc;
                    gotOp.push_back(heldOp); gotFirst.push_back(heldFirst);
                end else begin
                    op_ack = 1'b0; waitLeft--; waits++;
                end
            end else begin
                op_ack = 1'($urandom_range(0, 1));
            end

            if (stalled) begin
                checkVal({tag, " stall_valid"}, 64'(out_valid), 64'(1));
                checkVal({tag, " stall_data"}, 64'(out_data), 64'(heldData));
            end
            stalled = 0;
            if (out_valid) begin
                if (firstOutCyc < 0) firstOutCyc = cyc;
                if (abortWord >= 0 && gotW.size() == abortWord) begin
                    abort = 1'b1; out_ready = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    checkVal({tag, " abort_out_valid"}, 64'(out_valid), 64'(0));
                    checkVal({tag, " abort_busy"}, 64'(busy), 64'(0));
                    checkVal({tag, " abort_done"}, 64'(done), 64'(0));
                    aborted = 1;
                    break;
                end
                case (readyMode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (kReady % 3 == 0);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                kReady++;
                if (out_ready) gotW.push_back(out_data);
                else begin
                    stalled = 1; heldData = out_data; stalls++;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end

            if (junk && busy) begin
                prog_we = 1'($urandom_range(0, 1)); prog_addr = AW'($urandom);
                prog_data = OW'($urandom); start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end
        prog_we = 1'b0; start = 1'b0; op_ack = 1'b0; out_ready = 1'b0;

        checkVal({tag, " issue_count"}, 64'(gotOp.size()), 64'(expOp.size()));
        for (int i = 0; i < gotOp.size() && i < expOp.size(); i++) begin
            checkVal({tag, " op_code"}, 64'(gotOp[i]), 64'(expOp[i]));
            checkVal({tag, " op_first"}, 64'(gotFirst[i]), 64'(expFirst[i]));
        end
        for (int i = 0; i < gotW.size() && i < NW; i++)
            checkVal({tag, " word"}, 64'(gotW[i]), 64'(expW[i]));

        if (aborted) begin
            checkVal({tag, " abort_words"}, 64'(gotW.size()), 64'(abortWord));
            checkVal({tag, " abort_no_done"}, 64'(doneCnt), 64'(0));
        end else begin
            checkVal({tag, " finished"}, 64'(finished), 64'(1));
            checkVal({tag, " word_count"}, 64'(gotW.size()), 64'(NW));
            checkVal({tag, " done_pulses"}, 64'(doneCnt), 64'(1));
            // Busy spans issues (+waits), capture, words (+stalls) and the done cycle.
            checkVal({tag, " busy_cycles"}, 64'(busyCnt),
                     64'(expOp.size() + waits + 1 + NW + stalls + 1));
            if (len > 0) begin
                checkVal({tag, " start_to_op"}, 64'(firstOpCyc), 64'(1));
                checkVal({tag, " ack_to_out"}, 64'(firstOutCyc), 64'(lastAckCyc + 2));
            end else begin
                checkVal({tag, " no_op_valid"}, 64'(opSeen), 64'(0));
                checkVal({tag, " start_to_out"}, 64'(firstOutCyc), 64'(2));
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkVal("reset_outputs",
                 64'({op_valid, op_code, op_first, out_valid, out_data, busy, done}), 64'(0));
        rst = 1'b1;

        writeProg(0, 16'h5D11);
        writeProg(1, 16'h4973);
        runSeq("basic",     2, 1, 0, 0, -1, 0, 0, '0, 32'h0030_1800);
        runSeq("passes3",   2, 3, 1, 0, -1, 0, 0, '0, 32'h0030_1800);
        runSeq("passes0",   2, 0, 0, 0, -1, 0, 0, '0, 32'hA5C3_0F96);
        runSeq("len0",      0, 2, 0, 0, -1, 0, 0, '0, 32'h1234_5678);
        runSeq("stall",     2, 1, 0, 1, -1, 0, 0, '0, 32'hDEAD_BEEF);
        runSeq("abort",     2, 1, 0, 0,  1, 0, 0, '0, 32'hCAFE_F00D);
        runSeq("restart",   2, 1, 0, 0, -1, 0, 0, '0, 32'hCAFE_F00D);
        runSeq("wr_start",  2, 1, 0, 0, -1, 0, 1, 16'h0BAD, 32'h0102_0304);

        // Async reset in the middle of ISSUE.
        @(negedge clk);
        prog_len = 3'd2; passes = 4'd1; start = 1'b1; op_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkVal("pre_reset_op_valid", 64'(op_valid), 64'(1));
        #2 rst = 1'b0;
        #1 checkVal("async_reset_outputs",
                    64'({op_valid, op_code, op_first, out_valid, out_data, busy, done}), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        for (int a = 0; a < DEPTH; a++) writeProg(a, OW'($urandom));
        runSeq("junk_busy", 3, 2, 2, 2, -1, 1, 0, '0, IB'($urandom));
        for (int n = 0; n < 8; n++)
            runSeq("random", int'($urandom_range(0, DEPTH)), int'($urandom_range(0, 3)),
                   2, 2, -1, 1, 0, '0, IB'($urandom));

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
`default_nettype wire
